// File: rtl/sram_mem_ctrl.sv
// MEM-stage memory controller: performs each 32-bit load/store as two 16-bit
// beats on an external asynchronous SRAM and stalls the pipeline via ready.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WIDX_W = 17;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_wr_q;
  logic [WIDX_W-1:0]   widx_q;
  logic [31:0]         wdata_q;

  logic                req;
  logic                busy;
  logic                beat;
  logic                last;
  logic [31:0]         offset;
  logic                unused_offset_bits;

  assign req    = wr_en | rd_en;
  assign busy   = (state_q == LOW) || (state_q == HIGH);
  assign beat   = (state_q == HIGH);
  assign last   = (cnt_q == CNT_LAST);
  assign offset = address - 32'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // ready is a live function of the request so IDLE can stall in the same cycle
  assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

  // State and beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch; inputs are ignored once the access has left IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && req) begin
      op_wr_q <= wr_en;
      widx_q  <= offset[18:2];
      wdata_q <= write_data;
    end
  end

  // Load data capture on the last cycle of each read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
    end else if (busy && !op_wr_q && last) begin
      if (beat) read_data[31:16] <= sram_dq_in;
      else      read_data[15:0]  <= sram_dq_in;
    end
  end

  // Next-state and SRAM strobe decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) state_d = LOW;
      end
      LOW, HIGH: begin
        if (last) begin
          cnt_d   = '0;
          state_d = beat ? DONE : HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        sram_addr = {widx_q, beat};
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        if (op_wr_q) begin
          sram_dq_out = beat ? wdata_q[31:16] : wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          // final cycle of a write beat holds data with we_n released
          sram_we_n   = last;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural async SRAM model.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_low_cnt = 0;
  int oe_low_cnt = 0;

  logic [15:0] mem [0:15];

  sram_mem_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // SRAM model: write while we_n low, read while oe_n low
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
  end

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0000;

  always @(negedge clk) begin
    if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
    if (!sram_oe_n) oe_low_cnt <= oe_low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 after DONE with enables dropped
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int stall,
                        output logic [31:0] rdata_done, output logic seen_done);
    wr_en = w; rd_en = r; address = a; write_data = d;
    stall = 0;
    seen_done = 1'b0;
    rdata_done = 32'hxxxx_xxxx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        seen_done = 1'b1;
        rdata_done = read_data;
        break;
      end
      stall++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  int          stall;
  logic [31:0] rd;
  logic        ok;
  int          we0, oe0, c0;

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0;
    address = 32'h0; write_data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready_req", {31'd0, ready}, 32'd0);
    check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    wr_en = 1'b0; #1;
    check("rst_ready_idle", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write 0xDEADBEEF at 0x400
    we0 = we_low_cnt; oe0 = oe_low_cnt;
    access(1'b1, 1'b0, 32'h400, 32'hDEADBEEF, stall, rd, ok);
    check("wr0_done", {31'd0, ok}, 32'd1);
    check("wr0_stall", stall, 5);
    check("wr0_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("wr0_mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    check("wr0_we_cycles", we_low_cnt - we0, 2);
    check("wr0_oe_cycles", oe_low_cnt - oe0, 0);
    check("wr0_rdata_unchanged", rd, 32'd0);

    // read it back
    access(1'b0, 1'b1, 32'h400, 32'h0, stall, rd, ok);
    check("rd0_stall", stall, 5);
    check("rd0_data", rd, 32'hDEADBEEF);

    // address map
    access(1'b1, 1'b0, 32'h408, 32'h12345678, stall, rd, ok);
    check("wr1_mem4", {16'd0, mem[4]}, 32'h00005678);
    check("wr1_mem5", {16'd0, mem[5]}, 32'h00001234);

    // word index wraps modulo 2^17
    access(1'b1, 1'b0, 32'h400 + 32'd4 * 32'd131072, 32'hCAFEF00D, stall, rd, ok);
    check("wrap_mem0", {16'd0, mem[0]}, 32'h0000F00D);
    check("wrap_mem1", {16'd0, mem[1]}, 32'h0000CAFE);

    // simultaneous enables: write wins, read_data holds
    oe0 = oe_low_cnt;
    access(1'b1, 1'b1, 32'h410, 32'hA5A5A5A5, stall, rd, ok);
    check("both_stall", stall, 5);
    check("both_mem8", {16'd0, mem[8]}, 32'h0000A5A5);
    check("both_mem9", {16'd0, mem[9]}, 32'h0000A5A5);
    check("both_rdata_held", rd, 32'hDEADBEEF);
    check("both_oe_cycles", oe_low_cnt - oe0, 0);

    // back-to-back reads, second issued the cycle after DONE
    c0 = cyc;
    access(1'b0, 1'b1, 32'h400, 32'h0, stall, rd, ok);
    check("b2b0_stall", stall, 5);
    check("b2b0_data", rd, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'h408, 32'h0, stall, rd, ok);
    check("b2b1_stall", stall, 5);
    check("b2b1_data", rd, 32'h12345678);
    check("b2b_cycles", cyc - c0, 12);

    // reset during the HIGH beat of a read
    rd_en = 1'b1; address = 32'h400;
    repeat (4) @(negedge clk);
    check("mid_in_high_oe", {31'd0, sram_oe_n}, 32'd0);
    check("mid_in_high_addr", {14'd0, sram_addr}, 32'h1);
    check("mid_low_captured", {16'd0, read_data[15:0]}, 32'h0000F00D);
    rst_n = 1'b0; #1;
    check("mid_rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
    check("mid_rst_rdata", read_data, 32'd0);
    check("mid_rst_ready_req", {31'd0, ready}, 32'd0);
    rd_en = 1'b0; #1;
    check("mid_rst_ready_idle", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h408, 32'h0, stall, rd, ok);
    check("post_rst_stall", stall, 5);
    check("post_rst_data", rd, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
